// File: rtl/maze_pkg.sv
// Shared definitions for the maze memory arbiter: grant states, coordinate width
// and requester ids.
package maze_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        G0   = 2'd1,
        G1   = 2'd2
    } state_t;

    localparam int   MAZE_ADDR_W = 4;
    localparam logic REQ_SOLVER  = 1'b0;
    localparam logic REQ_AUX     = 1'b1;

endpackage

// File: rtl/rr_pick2.sv
// Combinational 2-way round-robin picker: a tie goes to the requester that was
// not granted last.
module rr_pick2
    import maze_pkg::*;
(
    input  logic [1:0] cand,
    input  logic       last,
    output logic       vld,
    output logic       id
);

    always_comb begin
        vld = |cand;
        if (&cand) id = ~last;
        else       id = cand[REQ_AUX];
    end

endmodule

// File: rtl/maze_mem_arbiter.sv
// Round-robin arbiter sharing the single-port maze memory between the solver and an aux client.
// Optional burst lock is compiled in when MAZE_ARB_LOCK_EN is defined.
module maze_mem_arbiter
    import maze_pkg::*;
#(
    parameter int ADDR_W   = MAZE_ADDR_W,
    parameter int LOCK_MAX = 8
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              req0,
    input  logic              req1,
    input  logic              wr0,
    input  logic              wr1,
    input  logic [ADDR_W-1:0] x0,
    input  logic [ADDR_W-1:0] y0,
    input  logic [ADDR_W-1:0] x1,
    input  logic [ADDR_W-1:0] y1,
    input  logic              din0,
    input  logic              din1,
`ifdef MAZE_ARB_LOCK_EN
    input  logic              lock0,
    input  logic              lock1,
`endif
    output logic              ack0,
    output logic              ack1,
    output logic              dout0,
    output logic              dout1,
    output logic [ADDR_W-1:0] X,
    output logic [ADDR_W-1:0] Y,
    output logic              D_in,
    output logic              RD,
    output logic              WR,
    input  logic              D_out
);

    if (LOCK_MAX < 1) begin : g_lock_max_check
        $error("LOCK_MAX must be at least 1");
    end

    state_t     state;
    state_t     nxt;
    logic       last;
    logic [1:0] cand;
    logic       pick_vld;
    logic       pick_id;
    logic       g0;
    logic       g1;

    // The requester being acked this cycle still shows its old req, so it is
    // excluded from the next arbitration.
    assign cand = {req1 && (state != G1), req0 && (state != G0)};

    rr_pick2 u_pick (
        .cand (cand),
        .last (last),
        .vld  (pick_vld),
        .id   (pick_id)
    );

`ifdef MAZE_ARB_LOCK_EN
    localparam int CNT_W = $clog2(LOCK_MAX + 1);
    logic [CNT_W-1:0] cnt;
    logic             cap_hit;

    assign cap_hit = (cnt >= CNT_W'(LOCK_MAX));
`endif

    always_comb begin
        nxt = IDLE;
        if (pick_vld) nxt = (pick_id == REQ_AUX) ? G1 : G0;
`ifdef MAZE_ARB_LOCK_EN
        if (state == G0 && lock0 && req0 && !(req1 && cap_hit))      nxt = G0;
        else if (state == G1 && lock1 && req1 && !(req0 && cap_hit)) nxt = G1;
`endif
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state <= IDLE;
            last  <= REQ_AUX;
        end else begin
            state <= nxt;
            if (nxt != IDLE) last <= (nxt == G1) ? REQ_AUX : REQ_SOLVER;
        end
    end

`ifdef MAZE_ARB_LOCK_EN
    // Counts grants in the current burst, including the one in progress.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST)                cnt <= '0;
        else if (nxt == IDLE)   cnt <= '0;
        else if (nxt != state)  cnt <= CNT_W'(1);
        else if (!cap_hit)      cnt <= cnt + 1'b1;
    end
`endif

    // A grant whose requester has already dropped req makes no access.
    assign g0 = (state == G0) && req0;
    assign g1 = (state == G1) && req1;

    always_comb begin
        X     = '0;
        Y     = '0;
        D_in  = 1'b0;
        RD    = 1'b0;
        WR    = 1'b0;
        ack0  = 1'b0;
        ack1  = 1'b0;
        dout0 = 1'b0;
        dout1 = 1'b0;
        if (g0) begin
            X     = x0;
            Y     = y0;
            D_in  = din0;
            WR    = wr0;
            RD    = !wr0;
            ack0  = 1'b1;
            dout0 = D_out;
        end else if (g1) begin
            X     = x1;
            Y     = y1;
            D_in  = din1;
            WR    = wr1;
            RD    = !wr1;
            ack1  = 1'b1;
            dout1 = D_out;
        end
    end

endmodule
